// File: rtl/truth_table_extractor_if.sv
// Handshake/bus bundle between the truth-table sweeper and its controller.
// The slave side is the sweeper; the master side is the controller.
interface truth_table_extractor_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
);
    localparam int TBL_W = N_OUT * (1 << N_IN);

    logic             start;
    logic [TBL_W-1:0] exp_table;
    logic [N_IN-1:0]  dut_in;
    logic [N_OUT-1:0] dut_out;
    logic             row_valid;
    logic             row_ready;
    logic [N_IN-1:0]  row_index;
    logic [N_OUT-1:0] row_value;
    logic [TBL_W-1:0] table_out;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        output start, exp_table, dut_out, row_ready,
        input  dut_in, row_valid, row_index, row_value, table_out, busy, done, pass
    );

    modport slave (
        input  start, exp_table, dut_out, row_ready,
        output dut_in, row_valid, row_index, row_value, table_out, busy, done, pass
    );
endinterface

// File: rtl/truth_table_extractor.sv
// Sweeps every input row of a combinational block, streams each sampled
// output row over valid/ready and checks the captured table against a reference.
module truth_table_extractor #(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_extractor_if.slave  bus
);
    localparam int ROWS  = 1 << N_IN;
    localparam int TBL_W = N_OUT * ROWS;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0]  LAST_ROW    = N_IN'(ROWS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_r;
    logic [N_IN-1:0]  row_r;
    logic [CNT_W-1:0] cnt_r;
    logic [N_IN-1:0]  dut_in_r;
    logic             row_valid_r;
    logic [N_IN-1:0]  row_index_r;
    logic [N_OUT-1:0] row_value_r;
    logic [TBL_W-1:0] table_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [TBL_W-1:0] table_ins_s;

    // Table with the live DUT output written into the current row's bit positions
    always_comb begin
        table_ins_s = table_r;
        for (int j = 0; j < N_OUT; j++) begin
            table_ins_s[j * ROWS + int'(row_r)] = bus.dut_out[j];
        end
    end

    // Sweep sequencer: state, counters and every registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            row_r       <= {N_IN{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            dut_in_r    <= {N_IN{1'b0}};
            row_valid_r <= 1'b0;
            row_index_r <= {N_IN{1'b0}};
            row_value_r <= {N_OUT{1'b0}};
            table_r     <= {TBL_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r  <= ST_SETTLE;
                        row_r    <= {N_IN{1'b0}};
                        dut_in_r <= {N_IN{1'b0}};
                        cnt_r    <= SETTLE_LOAD;
                        table_r  <= {TBL_W{1'b0}};
                        busy_r   <= 1'b1;
                        pass_r   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        row_value_r <= bus.dut_out;
                        row_index_r <= row_r;
                        table_r     <= table_ins_s;
                        row_valid_r <= 1'b1;
                        state_r     <= ST_EMIT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (bus.row_ready) begin
                        row_valid_r <= 1'b0;
                        if (row_r == LAST_ROW) begin
                            // Verdict is registered so it is valid throughout the done cycle
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            pass_r  <= (table_r == bus.exp_table);
                        end else begin
                            row_r    <= row_r + N_IN'(1);
                            dut_in_r <= row_r + N_IN'(1);
                            cnt_r    <= SETTLE_LOAD;
                            state_r  <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in    = dut_in_r;
    assign bus.row_valid = row_valid_r;
    assign bus.row_index = row_index_r;
    assign bus.row_value = row_value_r;
    assign bus.table_out = table_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pass      = pass_r;
endmodule

// File: tb/tb_truth_table_extractor.sv
// Directed bench for truth_table_extractor against a 3-in/2-out reference block
// whose rows 0..7 produce {o1,o0} = 2,3,3,1,3,3,3,3 (table 16'hF7FE).
module tb_truth_table_extractor;
    logic clk;
    logic rst_n;
    bit   glitch_on;
    int   checks;
    int   failures;

    truth_table_extractor_if #(.N_IN(3), .N_OUT(2)) bus ();

    truth_table_extractor #(.N_IN(3), .N_OUT(2), .SETTLE(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] model(input logic [2:0] r);
        case (r)
            3'd0:    return 2'b10;
            3'd3:    return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    assign bus.dut_out = glitch_on ? 2'b00 : model(bus.dut_in);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // One sweep; abort_row >= 0 asserts reset while that row is presented.
    task automatic sweep(input logic [15:0] exp_t, input int bp_row, input int bp_len,
                         input int glitch_row, input bit spam, input int abort_row,
                         output int n_done, output logic pass_o, output logic [15:0] tbl_o,
                         output int rows_o, output bit bad_o);
        int  n;
        int  bp_left;
        bit  glitched;
        n_done   = -1;
        pass_o   = 1'b0;
        tbl_o    = 16'h0;
        rows_o   = 0;
        bad_o    = 1'b0;
        bp_left  = bp_len;
        glitched = 1'b0;
        bus.exp_table = exp_t;
        bus.row_ready = 1'b1;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("table_cleared", 32'(bus.table_out), 32'h0);
        check("dut_in_row0", 32'(bus.dut_in), 32'd0);
        n = 0;
        while (n < 200) begin
            bus.start     = 1'b0;
            bus.row_ready = 1'b1;
            glitch_on     = 1'b0;
            if (bus.done) begin
                n_done = n;
                pass_o = bus.pass;
                tbl_o  = bus.table_out;
                if (spam) bus.start = 1'b1;
                break;
            end
            if (abort_row >= 0 && bus.row_valid && int'(bus.row_index) == abort_row) begin
                rst_n = 1'b0;
                #1;
                check("abort_outputs_zero",
                      32'({bus.row_valid, bus.busy, bus.done, bus.pass, bus.table_out,
                           bus.dut_in, bus.row_index, bus.row_value}), 32'h0);
                n_done = -2;
                break;
            end
            if (bus.row_valid) begin
                if (bus.row_value !== model(bus.row_index) || bus.dut_in !== bus.row_index)
                    bad_o = 1'b1;
                if (int'(bus.row_index) == bp_row && bp_left > 0) begin
                    bus.row_ready = 1'b0;
                    bp_left--;
                end else begin
                    if (int'(bus.row_index) != rows_o) bad_o = 1'b1;
                    rows_o++;
                end
            end else begin
                if (int'(bus.dut_in) == glitch_row && !glitched) begin
                    glitch_on = 1'b1;
                    glitched  = 1'b1;
                end
                if (spam && (bus.dut_in == 3'd2 || bus.dut_in == 3'd5)) bus.start = 1'b1;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          n_done;
        logic        pass_v;
        logic [15:0] tbl_v;
        int          rows_v;
        bit          bad_v;
        int          done_seen;
        checks = 0;
        failures = 0;
        glitch_on = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.row_ready = 1'b0;
        bus.exp_table = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_dut_in", 32'(bus.dut_in), 32'h0);
        check("rst_row_valid", 32'(bus.row_valid), 32'h0);
        check("rst_row_index_value", 32'({bus.row_index, bus.row_value}), 32'h0);
        check("rst_table_out", 32'(bus.table_out), 32'h0);
        check("rst_busy_done_pass", 32'({bus.busy, bus.done, bus.pass}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal sweep, matching reference
        sweep(16'hF7FE, -1, 0, -1, 1'b0, -1, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("nom_latency", 32'(n_done), 32'd24);
        check("nom_pass", 32'(pass_v), 32'd1);
        check("nom_table", 32'(tbl_v), 32'hF7FE);
        check("nom_rows", 32'(rows_v), 32'd8);
        check("nom_row_stream", 32'(bad_v), 32'd0);
        @(negedge clk);
        check("nom_done_one_cycle", 32'(bus.done), 32'd0);
        check("nom_busy_low_idle", 32'(bus.busy), 32'd0);
        check("nom_pass_held", 32'(bus.pass), 32'd1);
        check("nom_table_held", 32'(bus.table_out), 32'hF7FE);

        // Mismatching reference
        sweep(16'hF7FF, -1, 0, -1, 1'b0, -1, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("mis_table", 32'(tbl_v), 32'hF7FE);
        check("mis_pass", 32'(pass_v), 32'd0);
        @(negedge clk);

        // Backpressure of 5 cycles at row 3
        sweep(16'hF7FE, 3, 5, -1, 1'b0, -1, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("bp_latency", 32'(n_done), 32'd29);
        check("bp_stable_rows", 32'(bad_v), 32'd0);
        check("bp_pass", 32'(pass_v), 32'd1);
        @(negedge clk);

        // Glitch on first settle cycle of row 2 must not be captured
        sweep(16'hF7FE, -1, 0, 2, 1'b0, -1, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("glitch_table", 32'(tbl_v), 32'hF7FE);
        check("glitch_rows", 32'(bad_v), 32'd0);
        check("glitch_pass", 32'(pass_v), 32'd1);
        @(negedge clk);

        // Start pulses mid-sweep and in the done cycle are ignored
        sweep(16'hF7FE, -1, 0, -1, 1'b1, -1, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("spam_latency", 32'(n_done), 32'd24);
        check("spam_rows", 32'(rows_v), 32'd8);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        done_seen = 0;
        repeat (4) begin
            if (bus.done || bus.busy) done_seen++;
            @(negedge clk);
        end
        check("spam_no_restart", 32'(done_seen), 32'd0);
        sweep(16'hF7FE, -1, 0, -1, 1'b0, -1, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("restart_latency", 32'(n_done), 32'd24);
        check("restart_pass", 32'(pass_v), 32'd1);
        @(negedge clk);

        // Async reset during row 4 presentation
        sweep(16'hF7FE, -1, 0, -1, 1'b0, 4, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("abort_reached", 32'(n_done), 32'hFFFF_FFFE);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.row_valid) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(16'hF7FE, -1, 0, -1, 1'b0, -1, n_done, pass_v, tbl_v, rows_v, bad_v);
        check("post_abort_latency", 32'(n_done), 32'd24);
        check("post_abort_pass", 32'(pass_v), 32'd1);
        check("post_abort_table", 32'(tbl_v), 32'hF7FE);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
